// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sole driver of the 4-word x 4-bit bit-sliced RAM.
// Accepts read/write requests over valid/ready, sequences each access as
// setup -> hold (wordselect asserted) -> release so rw/data never move while
// a word is selected, and returns the result over a valid/ready response.
// After reset it can clear all four words before taking requests.
// HOLD_CYCLES must lie in 1..15.
module ram_access_ctrl #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned INIT_CLEAR  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [3:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_rdata,
    output logic       init_done,
    output logic       ram_rw,
    output logic [3:0] ram_data,
    output logic [3:0] ram_wordselect,
    input  logic [3:0] ram_out
);

    typedef enum logic [2:0] {
        INIT_SETUP   = 3'd0,
        INIT_ACCESS  = 3'd1,
        INIT_RELEASE = 3'd2,
        IDLE         = 3'd3,
        SETUP        = 3'd4,
        ACCESS       = 3'd5,
        RELEASE      = 3'd6,
        RESP         = 3'd7
    } state_t;

    // Last value of the hold counter inside an ACCESS phase.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    // Without the clear sequence the block is ready straight out of reset.
    localparam logic       NO_INIT   = (INIT_CLEAR == 0) ? 1'b1 : 1'b0;
    localparam state_t     RST_STATE = (INIT_CLEAR == 0) ? IDLE : INIT_SETUP;

    // Word address to one-hot wordselect.
    function automatic logic [3:0] addr_onehot(input logic [1:0] a);
        addr_onehot = 4'b0001 << a;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] hold_cnt_r, hold_cnt_s;
    logic [1:0] word_cnt_r, word_cnt_s;
    logic [1:0] addr_r, addr_s;
    logic       write_r, write_s;
    logic [3:0] wdata_r, wdata_s;
    logic       init_done_s;
    logic [3:0] rdata_s;
    logic       req_ready_s;
    logic       rsp_valid_s;
    logic       ram_rw_s;
    logic [3:0] ram_data_s;
    logic [3:0] ram_ws_s;

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        word_cnt_s  = word_cnt_r;
        addr_s      = addr_r;
        write_s     = write_r;
        wdata_s     = wdata_r;
        init_done_s = init_done;
        rdata_s     = rsp_rdata;
        case (state_r)
            INIT_SETUP: begin
                state_s    = INIT_ACCESS;
                hold_cnt_s = 4'd0;
            end
            INIT_ACCESS: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = INIT_RELEASE;
                    hold_cnt_s = 4'd0;
                end else begin
                    hold_cnt_s = hold_cnt_r + 4'd1;
                end
            end
            INIT_RELEASE: begin
                if (word_cnt_r == 2'd3) begin
                    state_s     = IDLE;
                    word_cnt_s  = 2'd0;
                    init_done_s = 1'b1;
                end else begin
                    state_s    = INIT_SETUP;
                    word_cnt_s = word_cnt_r + 2'd1;
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_s = SETUP;
                    addr_s  = req_addr;
                    write_s = req_write;
                    wdata_s = req_wdata;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s    = ACCESS;
                hold_cnt_s = 4'd0;
            end
            ACCESS: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = RELEASE;
                    hold_cnt_s = 4'd0;
                    // Sample the RAM while the word is still selected.
                    rdata_s    = write_r ? wdata_r : ram_out;
                end else begin
                    hold_cnt_s = hold_cnt_r + 4'd1;
                end
            end
            RELEASE: begin
                state_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = RST_STATE;
            end
        endcase
    end

    // Output values for the upcoming state, so every output is a flop.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        ram_rw_s    = 1'b0;
        ram_data_s  = 4'd0;
        ram_ws_s    = 4'd0;
        case (state_s)
            INIT_SETUP, INIT_RELEASE: begin
                ram_rw_s = 1'b1;
            end
            INIT_ACCESS: begin
                ram_rw_s = 1'b1;
                ram_ws_s = addr_onehot(word_cnt_s);
            end
            IDLE: begin
                req_ready_s = init_done_s;
            end
            SETUP, RELEASE: begin
                ram_rw_s   = write_s;
                ram_data_s = wdata_s;
            end
            ACCESS: begin
                ram_rw_s   = write_s;
                ram_data_s = wdata_s;
                ram_ws_s   = addr_onehot(addr_s);
            end
            RESP: begin
                rsp_valid_s = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // State, counters, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RST_STATE;
            hold_cnt_r     <= 4'd0;
            word_cnt_r     <= 2'd0;
            addr_r         <= 2'd0;
            write_r        <= 1'b0;
            wdata_r        <= 4'd0;
            req_ready      <= NO_INIT;
            init_done      <= NO_INIT;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 4'd0;
            ram_rw         <= 1'b0;
            ram_data       <= 4'd0;
            ram_wordselect <= 4'd0;
        end else begin
            state_r        <= state_s;
            hold_cnt_r     <= hold_cnt_s;
            word_cnt_r     <= word_cnt_s;
            addr_r         <= addr_s;
            write_r        <= write_s;
            wdata_r        <= wdata_s;
            req_ready      <= req_ready_s;
            init_done      <= init_done_s;
            rsp_valid      <= rsp_valid_s;
            rsp_rdata      <= rdata_s;
            ram_rw         <= ram_rw_s;
            ram_data       <= ram_data_s;
            ram_wordselect <= ram_ws_s;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the expected timeline.
module tb_ram_access_ctrl;

    localparam int H        = 2;
    localparam int INIT_LEN = 4 * (H + 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [3:0] req_wdata = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_rdata;
    logic       init_done;
    logic       ram_rw;
    logic [3:0] ram_data;
    logic [3:0] ram_wordselect;
    logic [3:0] ram_out;

    int total = 0;
    int bad   = 0;

    ram_access_ctrl #(.HOLD_CYCLES(H), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_rw(ram_rw), .ram_data(ram_data), .ram_wordselect(ram_wordselect),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ws_idx(input logic [3:0] ws);
        case (ws)
            4'b0010: ws_idx = 1;
            4'b0100: ws_idx = 2;
            4'b1000: ws_idx = 3;
            default: ws_idx = 0;
        endcase
    endfunction

    // Behavioural RAM: writes on the edge while selected with rw=1.
    logic [3:0] ram_arr [4];
    always @(posedge clk) begin
        if (ram_wordselect != 4'd0 && ram_rw) ram_arr[ws_idx(ram_wordselect)] <= ram_data;
    end
    always_comb ram_out = (ram_wordselect != 4'd0) ? ram_arr[ws_idx(ram_wordselect)] : 4'd0;

    // Reference model state.
    logic [3:0] ref_mem [4];
    bit         started = 1'b0;
    int         cyc = 0;
    bit         done_m = 1'b0;
    bit         busy = 1'b0;
    int         t = 0;
    bit         m_w;
    logic [1:0] m_a;
    logic [3:0] m_d, m_rsp;
    logic [3:0] prev_ws;
    logic       prev_rw;
    logic [3:0] prev_data;
    bit         prev_ok = 1'b0;
    int         e_ws, e_rw, e_data, e_rv, e_rr, e_done;

    // Model advance at each edge, then full output comparison 1 time unit later.
    always begin
        @(posedge clk);
        if (rst) begin
            started = 1'b1;
            cyc = 1; done_m = 1'b0; busy = 1'b0; t = 0;
            for (int i = 0; i < 4; i++) ref_mem[i] = 4'd0;
        end else if (started) begin
            if (busy) begin
                if (t >= H + 3 && rsp_ready) begin
                    busy = 1'b0; t = 0;
                end else begin
                    t++;
                end
            end else if (done_m && req_valid) begin
                busy = 1'b1; t = 1;
                m_w = req_write; m_a = req_addr; m_d = req_wdata;
                m_rsp = req_write ? req_wdata : ref_mem[req_addr];
                if (req_write) ref_mem[req_addr] = req_wdata;
            end
            cyc++;
            if (cyc >= INIT_LEN + 1) done_m = 1'b1;
        end
        #1;
        if (started) begin
            e_ws = 0; e_rw = 0; e_data = 0; e_rv = 0; e_rr = 0; e_done = 0;
            if (!done_m) begin
                if ((cyc - 1) % (H + 2) >= 1 && (cyc - 1) % (H + 2) <= H)
                    e_ws = 1 << ((cyc - 1) / (H + 2));
                e_rw = (cyc == 1) ? 0 : 1;
            end else begin
                e_done = 1;
                if (!busy) begin
                    e_rr = 1;
                end else if (t >= H + 3) begin
                    e_rv = 1;
                end else begin
                    e_rw = m_w; e_data = m_d;
                    if (t >= 2 && t <= H + 1) e_ws = 1 << m_a;
                end
            end
            chk("ws", ram_wordselect, e_ws);
            chk("rw", ram_rw, e_rw);
            chk("ram_data", ram_data, e_data);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("req_ready", req_ready, e_rr);
            chk("init_done", init_done, e_done);
            if (e_rv == 1) chk("rsp_rdata", rsp_rdata, m_rsp);
            chk("ws_onehot0", int'((ram_wordselect & (ram_wordselect - 4'd1)) == 4'd0), 1);
            if (prev_ok && prev_ws != 4'd0 && ram_wordselect != 4'd0) begin
                chk("rw_stable_sel", ram_rw, prev_rw);
                chk("data_stable_sel", ram_data, prev_data);
            end
            prev_ws = ram_wordselect; prev_rw = ram_rw; prev_data = ram_data; prev_ok = 1'b1;
        end
    end

    // One request/response transaction, entered and left at a negedge.
    task automatic send(input bit w, input logic [1:0] a, input logic [3:0] d, input int hold,
                        output logic [3:0] rd, output int lat, output int waited);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        waited = 0; lat = 0; rd = 4'd0;
        while (!req_ready && waited < 100) begin @(negedge clk); waited++; end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        rd = rsp_rdata;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [3:0] ws_log [17];
    logic       done_log [17];
    logic [3:0] exp_ws [17];
    logic [3:0] rd;
    int         lat, waited, n;

    // Directed scenarios followed by random traffic.
    initial begin
        exp_ws = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0,
                   4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Post-reset clear sequence, cycles 1..17.
        for (int c = 0; c < 17; c++) begin
            ws_log[c] = ram_wordselect;
            done_log[c] = init_done;
            if (c < 16) @(negedge clk);
        end
        for (int c = 0; c < 17; c++) chk("init_ws_seq", ws_log[c], exp_ws[c]);
        chk("init_done_c16", done_log[15], 0);
        chk("init_done_c17", done_log[16], 1);

        // Read right after init returns cleared word.
        send(1'b0, 2'd1, 4'd0, 0, rd, lat, waited);
        chk("rd_after_init", rd, 0);
        chk("latency", lat, H + 3);
        // Write addr 2 = A echoes A.
        send(1'b1, 2'd2, 4'hA, 0, rd, lat, waited);
        chk("wr_echo", rd, 4'hA);
        chk("wr_latency", lat, 5);
        // Read back addr 2.
        send(1'b0, 2'd2, 4'h3, 0, rd, lat, waited);
        chk("rd_addr2", rd, 4'hA);
        // Response stall, then back-to-back request.
        send(1'b1, 2'd3, 4'h5, 3, rd, lat, waited);
        chk("stall_echo", rd, 4'h5);
        send(1'b0, 2'd3, 4'h0, 0, rd, lat, waited);
        chk("b2b_wait", waited, 0);
        chk("b2b_rd", rd, 4'h5);

        // Reset during the second ACCESS cycle.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ws", ram_wordselect, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ws", ram_wordselect, 0);
        chk("rst_rw", ram_rw, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        n = 0;
        while (!init_done && n < 40) begin @(negedge clk); n++; end
        chk("reinit_len", n, INIT_LEN);
        send(1'b0, 2'd0, 4'd0, 0, rd, lat, waited);
        chk("rd_after_reinit", rd, 0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            send(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                 int'($urandom_range(2, 0)), rd, lat, waited);
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Sequencer that sits directly upstream of the 4-word x 4-bit bit-sliced RAM and is the only block driving its rw, data and one-hot wordselect lines. It accepts read/write requests over a valid/ready handshake, decodes the 2-bit address to one-hot wordselect, and applies a setup/hold-safe access sequence. It captures the RAM output and returns it over a valid/ready response channel. After reset it optionally clears all four words.

Parameters:
HOLD_CYCLES, 2, cycles wordselect stays asserted per access; legal range 1..15, 0 illegal.
INIT_CLEAR, 1, 1 = write 0 to words 0..3 after reset; 0 = skip.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  2  word address 0..3
req_wdata  in  4  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  4  read data; for writes, echoes the written data
init_done  out  1  post-reset clear complete
ram_rw  out  1  to RAM: 1 = write, 0 = read
ram_data  out  4  to RAM data
ram_wordselect  out  4  to RAM, one-hot or all-zero
ram_out  in  4  RAM read output

Behaviour:
- Reset (rst sampled high): state INIT (or IDLE if INIT_CLEAR=0), all outputs 0: req_ready, rsp_valid, rsp_rdata, init_done, ram_rw, ram_data, ram_wordselect. The hold counter and word counter are cleared.
- States: INIT_SETUP, INIT_ACCESS, INIT_RELEASE, IDLE, SETUP, ACCESS, RELEASE, RESP.
- All outputs are registered; no combinational path from inputs to outputs.
- req_ready = 1 only in IDLE with init_done = 1.
- A request is accepted when req_valid & req_ready are both high at an edge. addr, write and wdata are latched at that edge.
- SETUP (1 cycle): ram_rw and ram_data take the latched values; ram_wordselect = 0000.
- ACCESS (HOLD_CYCLES cycles): ram_wordselect = 1 << addr. ram_rw and ram_data are held.
- For reads, ram_out is captured into rsp_rdata at the edge ending the last ACCESS cycle.
- RELEASE (1 cycle): ram_wordselect = 0000; ram_rw and ram_data are still held.
- RESP: ram_rw = 0, ram_data = 0. rsp_valid = 1 and is held, with rsp_rdata stable, until rsp_ready is sampled high.
  - rsp_valid & rsp_ready at an edge: IDLE next cycle, rsp_valid = 0, req_ready = 1.
- Latency: request accepted at edge of cycle T → rsp_valid high in cycle T+3+HOLD_CYCLES. Minimum request-to-request period is HOLD_CYCLES+4 cycles.
- Invariants:
  - ram_rw and ram_data change only in cycles where ram_wordselect = 0000.
  - ram_wordselect is always one-hot or zero.
  - ram_rw = 0 in IDLE and RESP, so no stray writes occur.
- INIT (INIT_CLEAR=1): words 0,1,2,3 are written in turn, each via INIT_SETUP/INIT_ACCESS/INIT_RELEASE with rw=1 and data=0. No responses are produced.
  - Cycle 1 is the first cycle with rst low. Word k occupies cycles k*(H+2)+1 .. (k+1)*(H+2), where H = HOLD_CYCLES.
  - init_done = 1 and req_ready = 1 from cycle 4*(H+2)+1 onward.
- INIT_CLEAR=0: init_done = 1 and req_ready = 1 from cycle 1.
- init_done stays 1 until the next reset.
- Requests offered during INIT are not accepted (req_ready = 0) and must be held by the source.
- Reset mid-operation: the in-flight request is dropped, no response is issued, and wordselect is 0000 in the cycle after rst is sampled. INIT reruns.
- Reset overrides a same-cycle handshake.

Test Plan:
1. INIT_CLEAR=1, H=2, release rst → wordselect 0001,0001,0010,0010,0100,0100,1000,1000, each pair bracketed by cycles with ws=0000. rw=1, data=0 throughout. init_done rises in cycle 17.
2. Write addr 2, data 4'hA accepted at T → T+1: rw=1, data=A, ws=0000. T+2..T+3: ws=0100. T+4: ws=0000. T+5: rsp_valid=1, rsp_rdata=A.
3. Read addr 2, RAM model returning A when ws=0100 → rw=0 throughout, rsp_rdata=A at T+5. Reading addr 1 right after init → rsp_rdata=0.
4. Hold rsp_ready low 3 cycles → rsp_valid and rsp_rdata stable, req_ready=0. Raise rsp_ready → IDLE next cycle; a back-to-back request is accepted that cycle.
5. Assert rst during the second ACCESS cycle → next cycle ws=0000, all outputs 0. No rsp_valid. INIT sequence restarts.
6. 200 random read/write requests against a reference 4x4 array → all read data match, and the ws one-hot/zero and rw/data-stable-while-selected invariants hold every cycle.
